// File: rtl/mem_port_arbiter.sv
// ============================================================================
// Module   : mem_port_arbiter
// Brief    : Shares one single-ported memory between instruction fetch (I) and
//            load/store (D) requesters, with bounded D streaks and a watchdog.
// Revision : 1.0 - initial release
// ============================================================================
`default_nettype none

module mem_port_arbiter #(
  parameter int ADDR_W         = 32,
  parameter int DATA_W         = 32,
  parameter int MAX_D_STREAK   = 4,
  parameter int TIMEOUT_CYCLES = 255
) (
  input  logic                clk,
  input  logic                reset,
  // instruction-fetch requester
  input  logic                i_req,
  input  logic [ADDR_W-1:0]   i_addr,
  output logic                i_ack,
  output logic [DATA_W-1:0]   i_rdata,
  // load/store requester
  input  logic                d_req,
  input  logic [ADDR_W-1:0]   d_addr,
  input  logic                d_we,
  input  logic [DATA_W-1:0]   d_wdata,
  input  logic [DATA_W/8-1:0] d_be,
  output logic                d_ack,
  output logic [DATA_W-1:0]   d_rdata,
  output logic                bus_error,
  // memory port
  output logic                mem_req,
  output logic                mem_we,
  output logic [ADDR_W-1:0]   mem_addr,
  output logic [DATA_W-1:0]   mem_wdata,
  output logic [DATA_W/8-1:0] mem_be,
  input  logic                mem_ack,
  input  logic [DATA_W-1:0]   mem_rdata
);

  localparam int BE_W = DATA_W / 8;

  localparam logic [1:0] c_ST_IDLE = 2'd0;
  localparam logic [1:0] c_ST_WAIT = 2'd1;
  localparam logic [1:0] c_ST_RESP = 2'd2;

  localparam logic       c_OWNER_I      = 1'b0;
  localparam logic       c_OWNER_D      = 1'b1;
  localparam logic [3:0] c_MAX_STREAK   = 4'(MAX_D_STREAK);
  localparam logic [7:0] c_TIMER_LAST   = 8'(TIMEOUT_CYCLES - 1);

  logic [1:0]        state_q,     state_d;
  logic              owner_q,     owner_d;
  logic [3:0]        streak_q,    streak_d;
  logic [7:0]        timer_q,     timer_d;
  logic              err_q,       err_d;
  logic [DATA_W-1:0] rdata_q,     rdata_d;
  logic              mem_req_q,   mem_req_d;
  logic              mem_we_q,    mem_we_d;
  logic [ADDR_W-1:0] mem_addr_q,  mem_addr_d;
  logic [DATA_W-1:0] mem_wdata_q, mem_wdata_d;
  logic [BE_W-1:0]   mem_be_q,    mem_be_d;

  logic w_grant_d;
  logic w_grant_i;
  logic w_timeout;

  // D has priority until it has won MAX_D_STREAK times in a row over a waiting I
  assign w_grant_d = d_req && (!i_req || (streak_q < c_MAX_STREAK));
  assign w_grant_i = !w_grant_d && i_req;
  assign w_timeout = (timer_q == c_TIMER_LAST);

  // State register and datapath registers
  always_ff @(posedge clk) begin
    if (reset) begin
      state_q     <= c_ST_IDLE;
      owner_q     <= c_OWNER_I;
      streak_q    <= '0;
      timer_q     <= '0;
      err_q       <= 1'b0;
      rdata_q     <= '0;
      mem_req_q   <= 1'b0;
      mem_we_q    <= 1'b0;
      mem_addr_q  <= '0;
      mem_wdata_q <= '0;
      mem_be_q    <= '0;
    end else begin
      state_q     <= state_d;
      owner_q     <= owner_d;
      streak_q    <= streak_d;
      timer_q     <= timer_d;
      err_q       <= err_d;
      rdata_q     <= rdata_d;
      mem_req_q   <= mem_req_d;
      mem_we_q    <= mem_we_d;
      mem_addr_q  <= mem_addr_d;
      mem_wdata_q <= mem_wdata_d;
      mem_be_q    <= mem_be_d;
    end
  end

  // Next-state logic
  always_comb begin
    state_d = state_q;
    unique case (state_q)
      c_ST_IDLE: if (w_grant_d || w_grant_i) state_d = c_ST_WAIT;
      c_ST_WAIT: if (mem_ack || w_timeout)   state_d = c_ST_RESP;
      c_ST_RESP: state_d = c_ST_IDLE;
      default:   state_d = c_ST_IDLE;
    endcase
  end

  // Datapath next values
  always_comb begin
    owner_d     = owner_q;
    streak_d    = streak_q;
    timer_d     = timer_q;
    err_d       = err_q;
    rdata_d     = rdata_q;
    mem_req_d   = mem_req_q;
    mem_we_d    = mem_we_q;
    mem_addr_d  = mem_addr_q;
    mem_wdata_d = mem_wdata_q;
    mem_be_d    = mem_be_q;
    unique case (state_q)
      c_ST_IDLE: begin
        if (w_grant_d) begin
          owner_d     = c_OWNER_D;
          mem_req_d   = 1'b1;
          mem_we_d    = d_we;
          mem_addr_d  = d_addr;
          mem_wdata_d = d_wdata;
          mem_be_d    = d_be;
          timer_d     = '0;
          if (!i_req)
            streak_d = '0;
          else if (streak_q != c_MAX_STREAK)
            streak_d = streak_q + 4'd1;
        end else if (w_grant_i) begin
          owner_d     = c_OWNER_I;
          mem_req_d   = 1'b1;
          mem_we_d    = 1'b0;
          mem_addr_d  = i_addr;
          mem_wdata_d = '0;
          mem_be_d    = {BE_W{1'b1}};
          timer_d     = '0;
          streak_d    = '0;
        end
      end
      c_ST_WAIT: begin
        timer_d = timer_q + 8'd1;
        // a late ack on the watchdog's final cycle still counts as success
        if (mem_ack) begin
          rdata_d   = mem_rdata;
          err_d     = 1'b0;
          mem_req_d = 1'b0;
        end else if (w_timeout) begin
          rdata_d   = '0;
          err_d     = 1'b1;
          mem_req_d = 1'b0;
        end
      end
      default: ;
    endcase
  end

  // Outputs
  always_comb begin
    i_ack     = 1'b0;
    d_ack     = 1'b0;
    i_rdata   = '0;
    d_rdata   = '0;
    bus_error = 1'b0;
    if (state_q == c_ST_RESP) begin
      bus_error = err_q;
      if (owner_q == c_OWNER_D) begin
        d_ack   = 1'b1;
        d_rdata = rdata_q;
      end else begin
        i_ack   = 1'b1;
        i_rdata = rdata_q;
      end
    end
  end

  assign mem_req   = mem_req_q;
  assign mem_we    = mem_we_q;
  assign mem_addr  = mem_addr_q;
  assign mem_wdata = mem_wdata_q;
  assign mem_be    = mem_be_q;

endmodule

`default_nettype wire

// File: tb/tb_mem_port_arbiter.sv
// ============================================================================
// Module   : tb_mem_port_arbiter
// Brief    : Self-checking bench for mem_port_arbiter (vector table + scoreboard).
// Revision : 1.0 - initial release
// ============================================================================
`default_nettype none

module tb_mem_port_arbiter;

  localparam int AW   = 32;
  localparam int DW   = 32;
  localparam int BW   = 4;
  localparam int MAXS = 4;
  localparam int TO   = 8;

  typedef struct {
    bit          is_d;
    bit          we;
    logic [31:0] addr;
    logic [31:0] wdata;
    logic [3:0]  be;
    int          lat;     // mem_ack issued on mem_req cycle lat+1; <0 = never
    logic [31:0] rdata;
  } vec_t;

  typedef struct {
    bit          is_d;
    logic [31:0] rdata;
    bit          err;
    int          req_cycles;
  } exp_t;

  logic          clk = 1'b0;
  logic          reset;
  logic          i_req, d_req, d_we;
  logic [AW-1:0] i_addr, d_addr;
  logic [DW-1:0] d_wdata;
  logic [BW-1:0] d_be;
  logic          i_ack, d_ack, bus_error;
  logic [DW-1:0] i_rdata, d_rdata;
  logic          mem_req, mem_we;
  logic [AW-1:0] mem_addr;
  logic [DW-1:0] mem_wdata;
  logic [BW-1:0] mem_be;
  wire           mem_ack;
  logic [DW-1:0] mem_rdata;

  logic ack_auto, stray_ack;
  int   mem_lat;
  int   checks   = 0;
  int   failures = 0;
  exp_t sb[$];
  vec_t vecs[8];

  assign mem_ack = ack_auto | stray_ack;

  always #5 clk = ~clk;

  mem_port_arbiter #(
    .ADDR_W(AW), .DATA_W(DW), .MAX_D_STREAK(MAXS), .TIMEOUT_CYCLES(TO)
  ) dut (
    .clk(clk), .reset(reset),
    .i_req(i_req), .i_addr(i_addr), .i_ack(i_ack), .i_rdata(i_rdata),
    .d_req(d_req), .d_addr(d_addr), .d_we(d_we), .d_wdata(d_wdata), .d_be(d_be),
    .d_ack(d_ack), .d_rdata(d_rdata), .bus_error(bus_error),
    .mem_req(mem_req), .mem_we(mem_we), .mem_addr(mem_addr), .mem_wdata(mem_wdata),
    .mem_be(mem_be), .mem_ack(mem_ack), .mem_rdata(mem_rdata)
  );

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s: got=%0h want=%0h", name, act, exp);
    end
  endtask

  function automatic vec_t mk(input bit is_d, input bit we, input logic [31:0] addr,
                              input logic [31:0] wdata, input logic [3:0] be,
                              input int lat, input logic [31:0] rdata);
    vec_t v;
    v.is_d = is_d; v.we = we; v.addr = addr; v.wdata = wdata;
    v.be = be; v.lat = lat; v.rdata = rdata;
    return v;
  endfunction

  // Memory model: acks after mem_lat extra cycles of mem_req
  initial begin
    int cnt;
    ack_auto = 1'b0;
    cnt = 0;
    forever begin
      @(negedge clk);
      if (mem_req === 1'b1 && !ack_auto) begin
        if (mem_lat >= 0 && cnt == mem_lat) ack_auto = 1'b1;
        cnt++;
      end else begin
        ack_auto = 1'b0;
        cnt = 0;
      end
    end
  end

  task automatic run_vector(input int idx, input vec_t v);
    exp_t        e, got;
    int          cyc, reqcnt;
    bit          done, stable, tmo;
    logic [31:0] f_addr, f_wdata;
    logic [3:0]  f_be;
    logic        f_we;
    tmo = (v.lat < 0) || (v.lat >= TO);
    @(negedge clk);
    if (v.is_d) begin
      d_req = 1'b1; d_we = v.we; d_addr = v.addr; d_wdata = v.wdata; d_be = v.be;
    end else begin
      i_req = 1'b1; i_addr = v.addr;
    end
    mem_lat   = v.lat;
    mem_rdata = v.rdata;
    e.is_d = v.is_d;
    e.err  = tmo;
    e.rdata = tmo ? 32'h0 : v.rdata;
    e.req_cycles = tmo ? TO : v.lat + 1;
    sb.push_back(e);
    cyc = 0; reqcnt = 0; done = 0; stable = 1;
    f_addr = '0; f_wdata = '0; f_be = '0; f_we = 1'b0;
    while (!done && cyc < 100) begin
      @(negedge clk);
      cyc++;
      if (mem_req) begin
        reqcnt++;
        if (reqcnt == 1) begin
          f_addr = mem_addr; f_wdata = mem_wdata; f_be = mem_be; f_we = mem_we;
          chk($sformatf("v%0d_mem_addr", idx), mem_addr, v.addr);
          chk($sformatf("v%0d_mem_we", idx), 32'(mem_we), v.is_d ? 32'(v.we) : 32'h0);
          chk($sformatf("v%0d_mem_wdata", idx), mem_wdata, v.is_d ? v.wdata : 32'h0);
          chk($sformatf("v%0d_mem_be", idx), 32'(mem_be), v.is_d ? 32'(v.be) : 32'hF);
        end else if (mem_addr !== f_addr || mem_wdata !== f_wdata ||
                     mem_be !== f_be || mem_we !== f_we) begin
          stable = 0;
        end
      end
      if (i_ack || d_ack) begin
        got = sb.pop_front();
        chk($sformatf("v%0d_owner_d_ack", idx), 32'(d_ack), 32'(got.is_d));
        chk($sformatf("v%0d_owner_i_ack", idx), 32'(i_ack), 32'(!got.is_d));
        chk($sformatf("v%0d_rdata", idx), got.is_d ? d_rdata : i_rdata, got.rdata);
        chk($sformatf("v%0d_other_rdata", idx), got.is_d ? i_rdata : d_rdata, 32'h0);
        chk($sformatf("v%0d_bus_error", idx), 32'(bus_error), 32'(got.err));
        chk($sformatf("v%0d_req_cycles", idx), 32'(reqcnt), 32'(got.req_cycles));
        chk($sformatf("v%0d_mem_stable", idx), 32'(stable), 32'h1);
        i_req = 1'b0; d_req = 1'b0;
        done = 1;
      end
    end
    if (!done) chk($sformatf("v%0d_ack_timeout", idx), 32'h0, 32'h1);
    @(negedge clk);
    chk($sformatf("v%0d_post_ack", idx),
        {i_ack, d_ack, bus_error, mem_req, (i_rdata != 0), (d_rdata != 0)}, 32'h0);
  endtask

  initial begin
    reset = 1'b1; i_req = 0; d_req = 0; d_we = 0; i_addr = '0; d_addr = '0;
    d_wdata = '0; d_be = '0; stray_ack = 0; mem_lat = -1; mem_rdata = '0;

    vecs[0] = mk(0, 0, 32'h0040_0000, 32'h0,         4'hF, 1, 32'h2408_0001);
    vecs[1] = mk(1, 1, 32'h1000_0004, 32'hDEAD_BEEF, 4'h3, 0, 32'h0000_0000);
    vecs[2] = mk(1, 0, 32'h2000_0010, 32'h0,         4'hF, 3, 32'hCAFE_F00D);
    vecs[3] = mk(1, 0, 32'h2000_0020, 32'h0,         4'hF, -1, 32'h7777_7777);
    vecs[4] = mk(0, 0, 32'h0040_0004, 32'h0,         4'hF, 0, 32'h1234_5678);
    vecs[5] = mk(1, 0, 32'h2000_0030, 32'h0,         4'hF, TO - 1, 32'h5A5A_A5A5);
    vecs[6] = mk(0, 0, 32'h0040_0008, 32'h0,         4'hF, 6, 32'h0BAD_CAFE);
    vecs[7] = mk(1, 1, 32'h3000_0000, 32'h0102_0304, 4'h8, 2, 32'hFFFF_0000);

    repeat (3) @(negedge clk);
    chk("rst_acks",  {i_ack, d_ack, bus_error}, 32'h0);
    chk("rst_mem_req", 32'(mem_req), 32'h0);
    chk("rst_mem_we",  32'(mem_we), 32'h0);
    chk("rst_mem_addr", mem_addr, 32'h0);
    chk("rst_mem_wdata", mem_wdata, 32'h0);
    chk("rst_mem_be", 32'(mem_be), 32'h0);
    chk("rst_rdata", i_rdata | d_rdata, 32'h0);
    reset = 1'b0;

    for (int i = 0; i < 8; i++) run_vector(i, vecs[i]);

    // Contention: both held, expect D x MAXS then I, twice
    begin
      int   acks, cyc;
      bit   prev_ack;
      exp_t e, got;
      @(negedge clk);
      i_req = 1; i_addr = 32'h0040_0100;
      d_req = 1; d_we = 0; d_addr = 32'h3000_0040; d_be = 4'hF;
      mem_lat = 0; mem_rdata = 32'h1111_2222;
      for (int r = 0; r < 2; r++)
        for (int k = 0; k <= MAXS; k++) begin
          e.is_d = (k < MAXS); e.rdata = 32'h1111_2222; e.err = 0; e.req_cycles = 1;
          sb.push_back(e);
        end
      acks = 0; cyc = 0; prev_ack = 0;
      while (acks < 10 && cyc < 300) begin
        @(negedge clk);
        cyc++;
        if (i_ack || d_ack) begin
          got = sb.pop_front();
          chk($sformatf("cont%0d_owner", acks), 32'(d_ack), 32'(got.is_d));
          chk($sformatf("cont%0d_both_ack", acks), 32'(i_ack & d_ack), 32'h0);
          chk($sformatf("cont%0d_single", acks), 32'(prev_ack), 32'h0);
          chk($sformatf("cont%0d_rdata", acks), d_ack ? d_rdata : i_rdata, got.rdata);
          acks++;
          if (acks == 10) begin i_req = 0; d_req = 0; end
        end
        prev_ack = i_ack | d_ack;
      end
      chk("cont_ack_count", 32'(acks), 32'd10);
      @(negedge clk);
      chk("cont_last_single", {i_ack, d_ack}, 32'h0);
    end

    // Reset during the third WAIT cycle of a fetch, then a stray mem_ack
    begin
      int n, cyc;
      bit seen;
      @(negedge clk);
      i_req = 1; i_addr = 32'h0040_0200; mem_lat = -1; mem_rdata = 32'h9999_0000;
      n = 0; cyc = 0; seen = 0;
      while (n < 3 && cyc < 50) begin
        @(negedge clk);
        cyc++;
        if (mem_req) n++;
        seen = seen | i_ack | d_ack;
      end
      chk("rstw_reached_wait", 32'(n), 32'd3);
      reset = 1; i_req = 0;
      @(negedge clk);
      chk("rstw_mem_req", 32'(mem_req), 32'h0);
      seen = seen | i_ack | d_ack;
      reset = 0; stray_ack = 1;
      @(negedge clk);
      seen = seen | i_ack | d_ack;
      stray_ack = 0;
      repeat (5) begin
        @(negedge clk);
        seen = seen | i_ack | d_ack | bus_error;
      end
      chk("rstw_no_ack", 32'(seen), 32'h0);
      chk("rstw_idle_mem_req", 32'(mem_req), 32'h0);
    end

    chk("sb_empty", 32'(sb.size()), 32'h0);
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule

`default_nettype wire

// File: doc/mem_port_arbiter.md
Name: mem_port_arbiter

Overview:
- Shares one single-ported external memory between the instruction-fetch requester (I) and the memory-stage load/store requester (D).
- Grants one requester at a time and registers its request onto the memory port.
- Waits for the memory's acknowledge, then returns read data and a one-cycle acknowledge to the owner.
- Sits between the fetch/memory pipeline stages and the memory controller; a timeout watchdog raises a bus error on a hung access.

Parameters:
- ADDR_W, 32, address width
- DATA_W, 32, data width
- MAX_D_STREAK, 4, consecutive D grants allowed while I is waiting before I is forced; range 1..15
- TIMEOUT_CYCLES, 255, cycles in WAIT without mem_ack before a bus error; range 1..255

Ports:
- clk  in  1  clock, rising edge
- reset  in  1  synchronous, active-high
- i_req  in  1  fetch request; held with i_addr until i_ack
- i_addr  in  ADDR_W  fetch address (read only)
- i_ack  out  1  one-cycle pulse: fetch complete, i_rdata valid
- i_rdata  out  DATA_W  fetch data; valid only while i_ack=1
- d_req  in  1  data request; held with d_addr/d_we/d_wdata/d_be until d_ack
- d_addr  in  ADDR_W  data address
- d_we  in  1  1=store, 0=load
- d_wdata  in  DATA_W  store data
- d_be  in  DATA_W/8  byte enables
- d_ack  out  1  one-cycle pulse: data access complete
- d_rdata  out  DATA_W  load data; valid only while d_ack=1
- bus_error  out  1  one-cycle pulse, coincident with i_ack/d_ack, when the access timed out
- mem_req  out  1  memory request; held until mem_ack
- mem_we  out  1  memory write
- mem_addr  out  ADDR_W  memory address
- mem_wdata  out  DATA_W  memory write data
- mem_be  out  DATA_W/8  memory byte enables; all ones for I reads
- mem_ack  in  1  memory access done; mem_rdata valid this cycle
- mem_rdata  in  DATA_W  memory read data

Behaviour:
- Reset values: all outputs 0; state IDLE; streak=0; timer=0; owner=I.
- Reset mid-access: at the next edge, state goes to IDLE and mem_req drops. The pending ack is discarded. A mem_ack arriving in IDLE is ignored.
- State IDLE, arbitration at each edge:
  - If d_req and (!i_req or streak<MAX_D_STREAK): grant D.
  - Else if i_req: grant I.
  - Else stay in IDLE.
- On a grant: register the owner and the mem_* fields (I: we=0, be=all ones, wdata=0), set mem_req=1, timer=0, go to WAIT.
- Streak counter:
  - D grant with i_req=1: streak+1, saturating at MAX_D_STREAK.
  - D grant with i_req=0: streak=0.
  - I grant: streak=0.
- State WAIT:
  - mem_* fields stay stable; timer increments each cycle.
  - mem_ack=1: capture mem_rdata into the owner's rdata register, set err=0, mem_req=0, go to RESP.
  - Else if timer==TIMEOUT_CYCLES-1: set rdata=0, err=1, mem_req=0, go to RESP.
  - mem_ack takes precedence if it arrives on the timeout cycle.
- State RESP:
  - Owner's ack=1 for exactly one cycle; bus_error=err.
  - The non-owner's ack and rdata stay 0; the owner's rdata is 0 outside its ack cycle.
  - Next edge: go to IDLE.
- Latency: request seen at edge 0 → mem_req high cycles 1..k, where k is the mem_ack cycle (k≥1) → owner ack in cycle k+1 → next grant at edge k+2. Minimum 3 cycles between grants.
- Requesters must not change their request fields while waiting. They may deassert req only after ack. A req still high in the ack cycle is treated as a new request.
- Simultaneous i_req and d_req: D wins unless the streak limit is reached; I is then served next, so no starvation.
- Memory data path and address checks belong downstream. The arbiter does no address checking.

Test Plan:
- Single fetch: i_req=1, i_addr=0x0040_0000; memory acks 2 cycles after mem_req → mem_addr=0x0040_0000, mem_we=0, mem_be=4'hF; i_ack one cycle with i_rdata=mem_rdata (0x2408_0001); d_ack stays 0.
- Store: d_req, d_we=1, d_addr=0x1000_0004, d_wdata=0xDEAD_BEEF, d_be=4'b0011 → exact values driven on mem_*; d_ack pulses once; bus_error=0.
- Contention: i_req and d_req held continuously, MAX_D_STREAK=4 → grant order D,D,D,D,I,D,D,D,D,I; every ack is a single cycle.
- Timeout: TIMEOUT_CYCLES=8, memory never acks → mem_req high exactly 8 cycles; then d_ack=1, bus_error=1, d_rdata=0; next request is granted normally.
- Reset mid-WAIT: assert reset during cycle 3 of an I access → mem_req=0, i_ack never pulses; a stray mem_ack after reset produces no ack.
- Ack on the timeout cycle: mem_ack arrives at timer==TIMEOUT_CYCLES-1 → normal ack with data, bus_error=0.
